// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control: Moore FSM that walks each instruction through
// fetch / decode / execute / memory / write-back and drives the datapath controls.
//
// state  | meaning
// -------+---------------------------------------------------------
// 0      | FETCH  : read instruction, PC+4 (waits on mem_ready)
// 1      | DECODE : register read, branch target into ALUOut
// 2      | MEMADR : effective address for lw/sw
// 3      | MEMRD  : data read (waits on mem_ready)
// 4      | MEMWB  : load result into rt
// 5      | MEMWR  : data write (waits on mem_ready)
// 6      | REXEC  : R-type ALU operation
// 7      | RWB    : R-type result into rd
// 8      | BRANCH : beq compare, conditional PC update
// 9      | JUMP   : PC <= jump target
// 10     | JR     : PC <= rs
// 11-15  | unused, recover to FETCH
module mc_main_control (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] state,
  output logic       illegal_op
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_REXEC  = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_JR     = 4'd10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'd8;

  logic [3:0] cur_state;
  logic [3:0] nxt_state;
  logic       legal_op;

  assign state    = cur_state;
  assign legal_op = (Opcode == OP_RTYPE) || (Opcode == OP_J) || (Opcode == OP_BEQ) ||
                    (Opcode == OP_LW) || (Opcode == OP_SW);

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cur_state <= S_FETCH;
    else          cur_state <= nxt_state;
  end

  // Next-state: memory states hold until mem_ready, DECODE dispatches on opcode.
  always_comb begin
    nxt_state = S_FETCH;
    case (cur_state)
      S_FETCH:  nxt_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: nxt_state = S_MEMADR;
          OP_RTYPE:     nxt_state = (Funct == FN_JR) ? S_JR : S_REXEC;
          OP_BEQ:       nxt_state = S_BRANCH;
          OP_J:         nxt_state = S_JUMP;
          default:      nxt_state = S_FETCH;
        endcase
      end
      S_MEMADR: nxt_state = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  nxt_state = mem_ready ? S_FETCH : S_MEMWR;
      S_REXEC:  nxt_state = S_RWB;
      default:  nxt_state = S_FETCH;
    endcase
  end

  // Moore outputs decoded from state; write strobes are gated off while reset is held
  // so nothing is written between reset assertion and the next instruction.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    illegal_op  = 1'b0;
    case (cur_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = ~legal_op;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
        ALUOp    = 2'b10;
      end
      default: ;
    endcase
    if (!reset_n) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemWrite    = 1'b0;
      illegal_op  = 1'b0;
    end
  end

endmodule
